// File: rtl/cpu_pkg.sv
// Definitions shared between the fetch stage and the control unit: opcodes,
// instruction field positions and the fetch FSM state type.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_LT  = 4'hA;
  localparam logic [3:0] OP_EQ  = 4'hB;
  localparam logic [3:0] OP_MVI = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Instruction layout: {opcode[15:12], dest[11:6], src[5:0]}
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned DST_MSB = 11;
  localparam int unsigned DST_LSB = 6;
  localparam int unsigned SRC_MSB = 5;
  localparam int unsigned SRC_LSB = 0;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_REQ   = 3'd1,
    FS_WAIT  = 3'd2,
    FS_ISSUE = 3'd3,
    FS_HALT  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_counter.sv
// Program counter for the fetch stage: synchronous reset to RESET_PC,
// load has priority over increment, increment wraps modulo 2^ADDR_W.
module pc_counter
  import cpu_pkg::*;
#(
  parameter int unsigned           ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads instructions from a synchronous ROM and issues them to the
// CU over valid/ready. Optional macro FETCH_JUMP_EN resolves JMP locally.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = OP_HLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               rom_read_enable,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [3:0]         opcode,
  output logic [5:0]         dest,
  output logic [5:0]         src,
  output logic               instr_valid,
  input  logic               cu_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  fetch_state_t       r_state;
  fetch_state_t       w_next;
  logic [INSTR_W-1:0] r_ir;
  logic [3:0]         w_rom_op;
  logic               w_pc_load;
  logic               w_pc_inc;
  logic [ADDR_W-1:0]  w_pc_load_val;
  logic [ADDR_W-1:0]  w_pc;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_pc_load),
    .i_load_val (w_pc_load_val),
    .i_inc      (w_pc_inc),
    .o_pc       (w_pc)
  );

  // Decoding in WAIT looks at the ROM word directly, the same value IR captures
  assign w_rom_op = rom_data[OPC_MSB:OPC_LSB];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FS_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir <= '0;
    end else if (r_state == FS_WAIT) begin
      r_ir <= rom_data;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_pc_load     = 1'b0;
    w_pc_inc      = 1'b0;
    w_pc_load_val = rom_data[ADDR_W-1:0];
    case (r_state)
      FS_IDLE: begin
        if (run) w_next = FS_REQ;
      end
      FS_REQ: begin
        w_next = FS_WAIT;
      end
      FS_WAIT: begin
        if (w_rom_op == HALT_OP) begin
          w_next = FS_HALT;
`ifdef FETCH_JUMP_EN
        end else if (w_rom_op == OP_JMP) begin
          w_pc_load = 1'b1;
          w_next    = FS_REQ;
`endif
        end else begin
          w_pc_inc = 1'b1;
          w_next   = FS_ISSUE;
        end
      end
      FS_ISSUE: begin
        if (cu_ready) w_next = run ? FS_REQ : FS_IDLE;
      end
      FS_HALT: begin
        w_next = FS_HALT;
      end
      default: begin
        w_next = FS_IDLE;
      end
    endcase
  end

  assign rom_read_enable = (r_state == FS_REQ);
  assign rom_address     = rom_read_enable ? w_pc : '0;
  assign opcode          = r_ir[OPC_MSB:OPC_LSB];
  assign dest            = r_ir[DST_MSB:DST_LSB];
  assign src             = r_ir[SRC_MSB:SRC_LSB];
  assign instr_valid     = (r_state == FS_ISSUE);
  assign halted          = (r_state == FS_HALT);
  assign pc              = w_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-level reference model predicts
// ROM read addresses and issued words; a negedge monitor checks the DUT.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        cu_ready = 1'b0;
  logic        rom_read_enable;
  logic [7:0]  rom_address;
  logic [15:0] rom_data = '0;
  logic [3:0]  opcode;
  logic [5:0]  dest;
  logic [5:0]  src;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halted;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W   (8),
    .INSTR_W  (16),
    .RESET_PC (8'h00),
    .HALT_OP  (4'hF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .rom_read_enable (rom_read_enable),
    .rom_address     (rom_address),
    .rom_data        (rom_data),
    .opcode          (opcode),
    .dest            (dest),
    .src             (src),
    .instr_valid     (instr_valid),
    .cu_ready        (cu_ready),
    .pc              (pc),
    .halted          (halted)
  );

  logic [15:0] rom [256];
  always @(posedge clk) if (rom_read_enable) rom_data <= rom[rom_address];

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;
  int n_reads = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  addr_q[$];
  logic [7:0]  m_final_pc;
  bit          m_halts;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h, nothing expected", name, act);
  endtask

  // Program-level model: walk the ROM from the reset PC as the ISA defines it
  task automatic build_model();
    logic [7:0]  p;
    logic [15:0] w;
    exp_q.delete();
    addr_q.delete();
    p       = 8'h00;
    m_halts = 1'b0;
    for (int k = 0; k < 600; k++) begin
      addr_q.push_back(p);
      w = rom[p];
      if (w[15:12] == 4'hF) begin
        m_halts = 1'b1;
        break;
      end
`ifdef FETCH_JUMP_EN
      if (w[15:12] == 4'hD) begin
        p = w[7:0];
        continue;
      end
`endif
      exp_q.push_back(w);
      p = p + 8'd1;
    end
    m_final_pc = p;
  endtask

  logic [15:0] held;
  bit          holding = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      holding = 1'b0;
    end else begin
      if (rom_read_enable) begin
        n_reads++;
        if (addr_q.size() == 0) fail_now("unexpected_read", 64'(rom_address));
        else chk("read_addr", 64'(rom_address), 64'(addr_q.pop_front()));
      end
      if (instr_valid) begin
        if (holding) chk("hold_fields", 64'({opcode, dest, src}), 64'(held));
        if (cu_ready) begin
          n_xfer++;
          holding = 1'b0;
          if (exp_q.size() == 0) fail_now("unexpected_issue", 64'({opcode, dest, src}));
          else chk("issue_word", 64'({opcode, dest, src}), 64'(exp_q.pop_front()));
        end else begin
          holding = 1'b1;
          held    = {opcode, dest, src};
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_word();
    logic [31:0] r;
    logic [3:0]  op;
    r  = $urandom();
    op = r[15:12];
`ifdef FETCH_JUMP_EN
    while (op == 4'hF || op == 4'hD) op = 4'($urandom_range(0, 12));
`else
    while (op == 4'hF) op = 4'($urandom_range(0, 14));
`endif
    return {op, r[11:0]};
  endfunction

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = rand_word();
  endtask

  // Reset pulse; leaves the bench at cycle 0 (first cycle out of reset)
  task automatic start(input bit run_v);
    tick();
    rst = 1'b1;
    run = run_v;
    build_model();
    n_reads = 0;
    n_xfer  = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_zero_outputs(input string name);
    chk(name, {29'd0, rom_read_enable, instr_valid, halted, opcode, dest, src, rom_address, pc}, 64'd0);
  endtask

  task automatic wait_valid(input string name);
    int c;
    c = 0;
    sample();
    while (!instr_valid && c < 40) begin
      tick();
      sample();
      c++;
    end
    if (!instr_valid) fail_now(name, 64'(c));
  endtask

  task automatic wait_halt(input string name, input int budget, input bit rnd);
    int c;
    c = 0;
    sample();
    while (!halted && c < budget) begin
      tick();
      if (rnd) begin
        run      = ($urandom_range(0, 9) != 0);
        cu_ready = ($urandom_range(0, 2) != 0);
      end
      sample();
      c++;
    end
    if (!halted) fail_now({name, "_halt_timeout"}, 64'(c));
    chk({name, "_halted"}, 64'(halted), 64'(m_halts));
    chk({name, "_final_pc"}, 64'(pc), 64'(m_final_pc));
    chk({name, "_issues_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_reads_left"}, 64'(addr_q.size()), 64'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [11:0] iv;
    logic [15:0] f0;
    logic [7:0]  pc0;
    int          r0;
    int          x0;
    int          c;

    // Directed program: MOV, MVI, HLT with a always-ready CU
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    rom[0] = 16'h1041;
    rom[1] = 16'hC085;
    rom[2] = 16'hF000;
    cu_ready = 1'b1;
    start(1'b1);
    iv = '0;
    for (int cy = 0; cy < 12; cy++) begin
      sample();
      iv[cy] = instr_valid;
      if (cy == 0) check_zero_outputs("t1_reset_outputs");
      tick();
    end
    chk("t1_valid_cycles", 64'(iv), 64'h048);
    sample();
    chk("t1_halted", 64'(halted), 64'd1);
    chk("t1_pc", 64'(pc), 64'h02);
    for (int cy = 0; cy < 10; cy++) begin
      tick();
      sample();
    end
    chk("t1_read_count", 64'(n_reads), 64'd3);
    chk("t1_xfer_count", 64'(n_xfer), 64'd2);

    // CU back-pressure holds the instruction
    fill_rom();
    rom[1] = 16'hF000;
    cu_ready = 1'b0;
    start(1'b1);
    wait_valid("t2_valid_timeout");
    f0  = {opcode, dest, src};
    pc0 = pc;
    r0  = n_reads;
    x0  = n_xfer;
    for (int cy = 0; cy < 5; cy++) begin
      tick();
      sample();
      chk("t2_valid_held", 64'(instr_valid), 64'd1);
      chk("t2_fields_held", 64'({opcode, dest, src}), 64'(f0));
      chk("t2_pc_held", 64'(pc), 64'(pc0));
    end
    chk("t2_no_read", 64'(n_reads), 64'(r0));
    tick();
    cu_ready = 1'b1;
    sample();
    tick();
    sample();
    chk("t2_one_transfer", 64'(n_xfer), 64'(x0 + 1));
    chk("t2_valid_drop", 64'(instr_valid), 64'd0);
    wait_halt("t2", 100, 1'b0);

    // PC wrap from 8'hFF to 8'h00
    fill_rom();
    cu_ready = 1'b1;
    start(1'b1);
    c = 0;
    sample();
    while (n_xfer < 256 && c < 3000) begin
      tick();
      cu_ready = ($urandom_range(0, 3) != 0);
      sample();
      c++;
    end
    chk("t3_reached_256", 64'(n_xfer), 64'd256);
    chk("t3_pc_wrapped", 64'(pc), 64'h00);
    cu_ready = 1'b1;
    c = 0;
    while (!rom_read_enable && c < 10) begin
      tick();
      sample();
      c++;
    end
    chk("t3_next_read_en", 64'(rom_read_enable), 64'd1);
    chk("t3_next_read_addr", 64'(rom_address), 64'h00);

    // Reset during WAIT, then during ISSUE with cu_ready high
    fill_rom();
    rom[4] = 16'hF000;
    cu_ready = 1'b1;
    start(1'b1);
    c = 0;
    sample();
    while (!rom_read_enable && c < 10) begin
      tick();
      sample();
      c++;
    end
    tick();
    rst = 1'b1;
    tick();
    sample();
    check_zero_outputs("t4_wait_reset_outputs");
    build_model();
    tick();
    rst = 1'b0;
    cu_ready = 1'b0;
    wait_valid("t4_valid_timeout");
    x0 = n_xfer;
    tick();
    rst = 1'b1;
    cu_ready = 1'b1;
    tick();
    sample();
    check_zero_outputs("t4_issue_reset_outputs");
    chk("t4_no_transfer", 64'(n_xfer), 64'(x0));
    build_model();
    tick();
    rst = 1'b0;
    wait_halt("t4", 100, 1'b0);

    // run low after reset, then run dropped during ISSUE
    fill_rom();
    rom[1] = 16'hF000;
    cu_ready = 1'b1;
    start(1'b0);
    for (int cy = 0; cy < 20; cy++) begin
      tick();
      sample();
    end
    chk("t5_idle_no_reads", 64'(n_reads), 64'd0);
    tick();
    run = 1'b1;
    cu_ready = 1'b0;
    wait_valid("t5_valid_timeout");
    x0 = n_xfer;
    tick();
    run = 1'b0;
    cu_ready = 1'b1;
    sample();
    chk("t5_transfer", 64'(n_xfer), 64'(x0 + 1));
    r0 = n_reads;
    for (int cy = 0; cy < 10; cy++) begin
      tick();
      sample();
    end
    chk("t5_idle_after", 64'({instr_valid, halted}), 64'd0);
    chk("t5_no_more_reads", 64'(n_reads), 64'(r0));

    // JMP handling (resolved locally only when FETCH_JUMP_EN is defined)
    fill_rom();
    rom[3]  = 16'hD00A;
    rom[4]  = 16'hF000;
    rom[10] = 16'hF000;
    cu_ready = 1'b1;
    start(1'b1);
    wait_halt("t6", 100, 1'b0);
`ifdef FETCH_JUMP_EN
    chk("t6_issue_count", 64'(n_xfer), 64'd3);
    chk("t6_pc", 64'(pc), 64'h0A);
`else
    chk("t6_issue_count", 64'(n_xfer), 64'd4);
    chk("t6_pc", 64'(pc), 64'h04);
`endif

    // Random programs with random run / cu_ready
    for (int it = 0; it < 8; it++) begin
      fill_rom();
      rom[$urandom_range(3, 40)] = 16'hF000;
      cu_ready = 1'b0;
      start(1'b1);
      wait_halt("rnd", 1500, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
